// File: rtl/point_centroid_sequencer_if.sv
// Accumulator-table access bus between the centroid sequencer (master) and the blob table (slave).
interface point_centroid_sequencer_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned SUM_W  = 32
);
  logic [ADDR_W-1:0] TBL_ADDR;
  logic              TBL_RD;
  logic              TBL_CLR;
  logic [SUM_W-1:0]  TBL_SUM_H;
  logic [SUM_W-1:0]  TBL_SUM_V;
  logic [15:0]       TBL_CNT;

  modport master (
    output TBL_ADDR, TBL_RD, TBL_CLR,
    input  TBL_SUM_H, TBL_SUM_V, TBL_CNT
  );

  modport slave (
    input  TBL_ADDR, TBL_RD, TBL_CLR,
    output TBL_SUM_H, TBL_SUM_V, TBL_CNT
  );
endinterface

// File: rtl/point_centroid_sequencer.sv
// Frame-end walker of the blob accumulator table: divides qualifying slots into centroids,
// publishes up to four points per frame and clears every slot behind it.
module point_centroid_sequencer #(
  parameter int unsigned NUM_SLOTS  = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned SUM_W      = 32,
  parameter int unsigned MIN_PIXELS = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       VGA_VS,
  point_centroid_sequencer_if.master tbl,
  output logic                       BUSY,
  output logic                       FRAME_DONE,
  output logic                       OVERRUN,
  output logic [2:0]                 POINT_COUNT,
  output logic [3:0]                 POINT_VALID,
  output logic [7:0]                 DROPPED,
  output logic [15:0]                POINTS_H_0,
  output logic [15:0]                POINTS_H_1,
  output logic [15:0]                POINTS_H_2,
  output logic [15:0]                POINTS_H_3,
  output logic [15:0]                POINTS_V_0,
  output logic [15:0]                POINTS_V_1,
  output logic [15:0]                POINTS_V_2,
  output logic [15:0]                POINTS_V_3
);
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned PT_W    = 16;
  localparam int unsigned NUM_PTS = 4;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned DROP_W  = 8;
  localparam int unsigned ITER_W  = $clog2(SUM_W);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WAIT, S_CHK, S_DIVH, S_DIVV, S_STORE, S_PUBLISH
  } state_e;

  state_e state_q, state_d;

  logic                              vs_q;
  logic [ADDR_W-1:0]                 slot_q, slot_d;
  logic [IDX_W-1:0]                  out_idx_q, out_idx_d;
  logic [SUM_W-1:0]                  sum_h_q, sum_h_d, sum_v_q, sum_v_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [SUM_W-1:0]                  quo_q, quo_d;
  logic [CNT_W-1:0]                  rem_q, rem_d;
  logic [ITER_W-1:0]                 iter_q, iter_d;
  logic [PT_W-1:0]                   qh_q, qh_d, qv_q, qv_d;
  logic [NUM_PTS-1:0][PT_W-1:0]      sh_h_q, sh_h_d, sh_v_q, sh_v_d;
  logic [NUM_PTS-1:0]                sh_valid_q, sh_valid_d;
  logic [DROP_W-1:0]                 drop_acc_q, drop_acc_d;

  logic [ADDR_W-1:0]                 tbl_addr_q, tbl_addr_d;
  logic                              tbl_rd_q, tbl_rd_d, tbl_clr_q, tbl_clr_d;
  logic                              busy_q, busy_d, frame_done_q, frame_done_d;
  logic                              overrun_q, overrun_d;
  logic [IDX_W-1:0]                  point_count_q, point_count_d;
  logic [NUM_PTS-1:0]                point_valid_q, point_valid_d;
  logic [DROP_W-1:0]                 dropped_q, dropped_d;
  logic [NUM_PTS-1:0][PT_W-1:0]      pts_h_q, pts_h_d, pts_v_q, pts_v_d;

  logic                              edge_c, qualify_c, last_slot_c, iter_last_c, room_c;
  logic [CNT_W:0]                    rem_sh_c, rem_sub_c;
  logic                              ge_c;
  logic [CNT_W-1:0]                  step_rem_c;
  logic [SUM_W-1:0]                  step_quo_c;

  function automatic logic [PT_W-1:0] sat_pt(input logic [SUM_W-1:0] q);
    return (q > SUM_W'({PT_W{1'b1}})) ? {PT_W{1'b1}} : q[PT_W-1:0];
  endfunction

  assign edge_c      = VGA_VS & ~vs_q;
  assign qualify_c   = cnt_q >= CNT_W'(MIN_PIXELS);
  assign last_slot_c = slot_q == ADDR_W'(NUM_SLOTS - 1);
  assign iter_last_c = iter_q == ITER_W'(SUM_W - 1);
  assign room_c      = out_idx_q < IDX_W'(NUM_PTS);

  // One restoring-division step shared by the H and V passes
  assign rem_sh_c   = {rem_q, quo_q[SUM_W-1]};
  assign rem_sub_c  = rem_sh_c - {1'b0, cnt_q};
  assign ge_c       = rem_sh_c >= {1'b0, cnt_q};
  assign step_rem_c = ge_c ? rem_sub_c[CNT_W-1:0] : rem_sh_c[CNT_W-1:0];
  assign step_quo_c = {quo_q[SUM_W-2:0], ge_c};

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (edge_c) state_d = S_RD;
      S_RD:      state_d = S_WAIT;
      S_WAIT:    state_d = S_CHK;
      S_CHK: begin
        if (qualify_c && room_c) state_d = S_DIVH;
        else if (last_slot_c)    state_d = S_PUBLISH;
        else                     state_d = S_RD;
      end
      S_DIVH:    if (iter_last_c) state_d = S_DIVV;
      S_DIVV:    if (iter_last_c) state_d = S_STORE;
      S_STORE:   state_d = last_slot_c ? S_PUBLISH : S_RD;
      S_PUBLISH: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    slot_d        = slot_q;
    out_idx_d     = out_idx_q;
    sum_h_d       = sum_h_q;
    sum_v_d       = sum_v_q;
    cnt_d         = cnt_q;
    quo_d         = quo_q;
    rem_d         = rem_q;
    iter_d        = iter_q;
    qh_d          = qh_q;
    qv_d          = qv_q;
    sh_h_d        = sh_h_q;
    sh_v_d        = sh_v_q;
    sh_valid_d    = sh_valid_q;
    drop_acc_d    = drop_acc_q;
    point_count_d = point_count_q;
    point_valid_d = point_valid_q;
    dropped_d     = dropped_q;
    pts_h_d       = pts_h_q;
    pts_v_d       = pts_v_q;

    case (state_q)
      S_IDLE: begin
        if (edge_c) begin
          slot_d    = '0;
          out_idx_d = '0;
        end
      end
      S_WAIT: begin
        sum_h_d = tbl.TBL_SUM_H;
        sum_v_d = tbl.TBL_SUM_V;
        cnt_d   = tbl.TBL_CNT;
      end
      S_CHK: begin
        if (qualify_c && room_c) begin
          quo_d  = sum_h_q;
          rem_d  = '0;
          iter_d = '0;
        end else begin
          if (qualify_c && drop_acc_q != {DROP_W{1'b1}})
            drop_acc_d = drop_acc_q + DROP_W'(1);
          if (!last_slot_c) slot_d = slot_q + ADDR_W'(1);
        end
      end
      S_DIVH: begin
        quo_d  = step_quo_c;
        rem_d  = step_rem_c;
        iter_d = iter_q + ITER_W'(1);
        if (iter_last_c) begin
          qh_d   = sat_pt(step_quo_c);
          quo_d  = sum_v_q;
          rem_d  = '0;
          iter_d = '0;
        end
      end
      S_DIVV: begin
        quo_d  = step_quo_c;
        rem_d  = step_rem_c;
        iter_d = iter_q + ITER_W'(1);
        if (iter_last_c) qv_d = sat_pt(step_quo_c);
      end
      S_STORE: begin
        sh_h_d[out_idx_q[1:0]]     = qh_q;
        sh_v_d[out_idx_q[1:0]]     = qv_q;
        sh_valid_d[out_idx_q[1:0]] = 1'b1;
        out_idx_d                  = out_idx_q + IDX_W'(1);
        if (!last_slot_c) slot_d = slot_q + ADDR_W'(1);
      end
      S_PUBLISH: begin
        sh_h_d     = '0;
        sh_v_d     = '0;
        sh_valid_d = '0;
        drop_acc_d = '0;
      end
      default: ;
    endcase

    // Outputs load on PUBLISH entry, forwarding any shadow write from the same edge
    if (state_d == S_PUBLISH) begin
      point_count_d = out_idx_d;
      point_valid_d = sh_valid_d;
      dropped_d     = drop_acc_d;
      for (int unsigned i = 0; i < NUM_PTS; i++) begin
        pts_h_d[i] = sh_valid_d[i] ? sh_h_d[i] : '0;
        pts_v_d[i] = sh_valid_d[i] ? sh_v_d[i] : '0;
      end
    end

    tbl_rd_d     = state_d == S_RD;
    tbl_clr_d    = state_d == S_CHK;
    tbl_addr_d   = (state_d != S_IDLE) ? slot_d : '0;
    busy_d       = state_d != S_IDLE;
    frame_done_d = state_d == S_PUBLISH;
    overrun_d    = edge_c && (state_q != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vs_q          <= 1'b0;
      slot_q        <= '0;
      out_idx_q     <= '0;
      sum_h_q       <= '0;
      sum_v_q       <= '0;
      cnt_q         <= '0;
      quo_q         <= '0;
      rem_q         <= '0;
      iter_q        <= '0;
      qh_q          <= '0;
      qv_q          <= '0;
      sh_h_q        <= '0;
      sh_v_q        <= '0;
      sh_valid_q    <= '0;
      drop_acc_q    <= '0;
      tbl_addr_q    <= '0;
      tbl_rd_q      <= 1'b0;
      tbl_clr_q     <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      point_count_q <= '0;
      point_valid_q <= '0;
      dropped_q     <= '0;
      pts_h_q       <= '0;
      pts_v_q       <= '0;
    end else begin
      vs_q          <= VGA_VS;
      slot_q        <= slot_d;
      out_idx_q     <= out_idx_d;
      sum_h_q       <= sum_h_d;
      sum_v_q       <= sum_v_d;
      cnt_q         <= cnt_d;
      quo_q         <= quo_d;
      rem_q         <= rem_d;
      iter_q        <= iter_d;
      qh_q          <= qh_d;
      qv_q          <= qv_d;
      sh_h_q        <= sh_h_d;
      sh_v_q        <= sh_v_d;
      sh_valid_q    <= sh_valid_d;
      drop_acc_q    <= drop_acc_d;
      tbl_addr_q    <= tbl_addr_d;
      tbl_rd_q      <= tbl_rd_d;
      tbl_clr_q     <= tbl_clr_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
      point_count_q <= point_count_d;
      point_valid_q <= point_valid_d;
      dropped_q     <= dropped_d;
      pts_h_q       <= pts_h_d;
      pts_v_q       <= pts_v_d;
    end
  end

  assign tbl.TBL_ADDR = tbl_addr_q;
  assign tbl.TBL_RD   = tbl_rd_q;
  assign tbl.TBL_CLR  = tbl_clr_q;
  assign BUSY         = busy_q;
  assign FRAME_DONE   = frame_done_q;
  assign OVERRUN      = overrun_q;
  assign POINT_COUNT  = point_count_q;
  assign POINT_VALID  = point_valid_q;
  assign DROPPED      = dropped_q;
  assign POINTS_H_0   = pts_h_q[0];
  assign POINTS_H_1   = pts_h_q[1];
  assign POINTS_H_2   = pts_h_q[2];
  assign POINTS_H_3   = pts_h_q[3];
  assign POINTS_V_0   = pts_v_q[0];
  assign POINTS_V_1   = pts_v_q[1];
  assign POINTS_V_2   = pts_v_q[2];
  assign POINTS_V_3   = pts_v_q[3];
endmodule
